// File: rtl/rbuf_rd.sv
// rbuf_rd: read side of the filter ring buffer.
// On an accepted start, reads all M samples from the shared BRAM, newest
// first, walking backwards from head_addr with wrap-around (0 -> M-1).
// The samples leave as a registered stream with dvalid/dlast, and done
// pulses one cycle after the last sample.
// The sample output port is named dout because "do" is a reserved word.
// The first read address is driven in the cycle right after start is
// sampled, so each read index equals its output sample index.
// Optional feature: define RBUF_RD_COEF_ADDR_EN to add the coef_addr
// output, a 0..M-1 index aligned with dout that addresses the
// coefficient ROM.
module rbuf_rd #(
    parameter int M         = 23,
    parameter int ADDR_SIZE = 5,
    parameter int DATA_SIZE = 16,
    parameter int READ_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] head_addr,
    output logic [ADDR_SIZE-1:0] addr,
    output logic                 re,
    input  logic [DATA_SIZE-1:0] bram_di,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dvalid,
    output logic                 dlast,
`ifdef RBUF_RD_COEF_ADDR_EN
    output logic [ADDR_SIZE-1:0] coef_addr,
`endif
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_SIZE:0]   DEPTH    = (ADDR_SIZE + 1)'(M);
    localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(M - 1);

    state_t                 state;
    logic [ADDR_SIZE-1:0]   ptr;       // address of the next read to issue
    logic [ADDR_SIZE-1:0]   cnt;       // index of the read currently on addr
    logic [ADDR_SIZE-1:0]   start_addr;
    logic                   rd_last;

    // One bit per outstanding read: vld_pipe tracks issued reads and
    // lst_pipe tracks which of them is the M-th one.
    logic [READ_LAT-1:0]    vld_pipe;
    logic [READ_LAT-1:0]    lst_pipe;
    logic [READ_LAT:0]      vld_in;
    logic [READ_LAT:0]      lst_in;
    logic                   tail_vld;
    logic                   tail_lst;

    // Ring-order predecessor: step back one slot, wrapping 0 -> M-1.
    function automatic logic [ADDR_SIZE-1:0] prev_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == '0) ? LAST_IDX : a - ADDR_SIZE'(1);
    endfunction

    // Clamp an out-of-range head to the last ring slot.
    assign start_addr = ({1'b0, head_addr} >= DEPTH) ? LAST_IDX : head_addr;
    assign rd_last    = re && (cnt == LAST_IDX);

    assign vld_in   = {vld_pipe, re};
    assign lst_in   = {lst_pipe, rd_last};
    assign tail_vld = vld_pipe[READ_LAT-1];
    assign tail_lst = lst_pipe[READ_LAT-1];

    // Pass control: one read per cycle in READ, then wait for the pipeline.
    // NOTE: all state is updated with non-blocking assignments so every
    // register in this block samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            addr  <= '0;
            re    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr  <= start_addr;
                        ptr   <= prev_addr(start_addr);
                        cnt   <= '0;
                        re    <= 1'b1;
                        busy  <= 1'b1;
                        state <= READ;
                    end
                end
                READ: begin
                    if (cnt == LAST_IDX) begin
                        re    <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        addr <= ptr;
                        ptr  <= prev_addr(ptr);
                        cnt  <= cnt + ADDR_SIZE'(1);
                        re   <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (dlast && !(|vld_pipe)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-latency tracking and registered output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
            dout     <= '0;
            dvalid   <= 1'b0;
            dlast    <= 1'b0;
        end else begin
            vld_pipe <= vld_in[READ_LAT-1:0];
            lst_pipe <= lst_in[READ_LAT-1:0];
            if (tail_vld) begin
                dout   <= bram_di;
                dvalid <= 1'b1;
                dlast  <= tail_lst;
            end else begin
                dvalid <= 1'b0;
                dlast  <= 1'b0;
            end
        end
    end

`ifdef RBUF_RD_COEF_ADDR_EN
    logic [ADDR_SIZE-1:0] coef_nxt;

    // Coefficient index: 0 on the first sample of a pass, +1 per sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coef_addr <= '0;
            coef_nxt  <= '0;
        end else if (tail_vld) begin
            coef_addr <= coef_nxt;
            coef_nxt  <= tail_lst ? '0 : coef_nxt + ADDR_SIZE'(1);
        end
    end
`endif

endmodule
